// File: rtl/dp_ram_be_if.sv
// -----------------------------------------------------------------------------
// dp_ram_be_if
// Bus bundle for the dual-port byte-enable RAM. Both ports' request fields
// and all read/collision responses travel together. The RAM connects through
// the slave modport, and the requester connects through the master modport.
//
// Signals (x = a | b):
//   data_x   [DATA_W]  write data
//   addr_x   [ADDR_W]  word address
//   we_x     [1]       write strobe
//   be_x     [BE_W]    byte enables, bit i covers data[8i+7:8i]
//   rd_x     [1]       read strobe
//   qx       [DATA_W]  read data, held until the next completed read
//   qx_valid [1]       one-cycle pulse when new read data appears
//   coll     [1]       one-cycle pulse on an overlapping same-address dual write
// -----------------------------------------------------------------------------
interface dp_ram_be_if #(
  parameter int DATA_W = 32'sd8,
  parameter int ADDR_W = 32'sd6,
  parameter int BE_W   = DATA_W / 32'sd8
);
  logic [DATA_W-1:0] data_a;
  logic [ADDR_W-1:0] addr_a;
  logic              we_a;
  logic [BE_W-1:0]   be_a;
  logic              rd_a;
  logic [DATA_W-1:0] data_b;
  logic [ADDR_W-1:0] addr_b;
  logic              we_b;
  logic [BE_W-1:0]   be_b;
  logic              rd_b;
  logic [DATA_W-1:0] qa;
  logic              qa_valid;
  logic [DATA_W-1:0] qb;
  logic              qb_valid;
  logic              coll;

  modport master (
    output data_a, addr_a, we_a, be_a, rd_a,
    output data_b, addr_b, we_b, be_b, rd_b,
    input  qa, qa_valid, qb, qb_valid, coll
  );

  modport slave (
    input  data_a, addr_a, we_a, be_a, rd_a,
    input  data_b, addr_b, we_b, be_b, rd_b,
    output qa, qa_valid, qb, qb_valid, coll
  );
endinterface

// File: rtl/dp_ram_be.sv
// -----------------------------------------------------------------------------
// dp_ram_be
// True dual-port synchronous RAM with per-byte write enables. Both ports run
// on one clock and are fully independent.
//
// Parameters:
//   DATA_W    word width, a multiple of 8
//   ADDR_W    address width, depth = 2**ADDR_W
//   BE_W      byte-enable width (derived from DATA_W)
//   RDW_MODE  same-port read-during-write: 0 = old word, 1 = merged new word
//   OUT_REG   1 adds an output register stage (read latency 2)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset. Release is synchronised inside
//          the block, so requests are taken from the third edge after the
//          rise.
//   bus    dp_ram_be_if slave: request fields and qa/qb, valids, coll
//
// Behaviour notes:
//   - On a same-address dual write, port A owns every byte it enables.
//     Port B lands only in the remaining bytes.
//   - A cross-port read sees the word as it was before this edge's writes.
//   - Memory contents have no reset. Output and pipeline registers do.
// -----------------------------------------------------------------------------
module dp_ram_be #(
  parameter int DATA_W   = 32'sd8,
  parameter int ADDR_W   = 32'sd6,
  parameter int BE_W     = DATA_W / 32'sd8,
  parameter int RDW_MODE = 32'sd0,
  parameter int OUT_REG  = 32'sd0
) (
  input  logic       clk,
  input  logic       rst_n,
  dp_ram_be_if.slave bus
);

  localparam int                DEPTH       = 32'sd2 ** ADDR_W;
  localparam bit                WRITE_FIRST = (RDW_MODE != 32'sd0);
  localparam logic [BE_W-1:0]   BE_ZERO     = {BE_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO   = {DATA_W{1'b0}};

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rst_s1_q, rst_s1_d;
  logic              rst_s2_q, rst_s2_d;
  logic              en_s;

  logic              wr_a_s, wr_b_s, rd_a_s, rd_b_s, same_addr_s;
  logic [BE_W-1:0]   be_a_eff_s, be_b_eff_s;
  logic [DATA_W-1:0] old_a_s, old_b_s, post_a_s, post_b_s;
  logic [DATA_W-1:0] rdat_a_s, rdat_b_s;

  logic [DATA_W-1:0] s1_qa_q, s1_qa_d, s1_qb_q, s1_qb_d;
  logic              s1_va_q, s1_va_d, s1_vb_q, s1_vb_d;
  logic              coll_q, coll_d;

  // Release synchroniser next state: shift ones in while rst_n is high.
  always_comb begin
    rst_s1_d = 1'b1;
    rst_s2_d = rst_s1_q;
  end

  // Release synchroniser flops. Assertion clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
    end else begin
      rst_s1_q <= rst_s1_d;
      rst_s2_q <= rst_s2_d;
    end
  end

  // Requests are honoured only once the synchroniser has seen two high edges.
  assign en_s = rst_s2_q;

  // Request qualification and byte-lane arbitration (port A owns shared bytes).
  always_comb begin
    wr_a_s      = en_s & bus.we_a;
    wr_b_s      = en_s & bus.we_b;
    rd_a_s      = en_s & bus.rd_a;
    rd_b_s      = en_s & bus.rd_b;
    same_addr_s = (bus.addr_a == bus.addr_b);
    if (wr_a_s) begin
      be_a_eff_s = bus.be_a;
    end else begin
      be_a_eff_s = BE_ZERO;
    end
    if (wr_b_s && same_addr_s) begin
      be_b_eff_s = bus.be_b & ~be_a_eff_s;
    end else if (wr_b_s) begin
      be_b_eff_s = bus.be_b;
    end else begin
      be_b_eff_s = BE_ZERO;
    end
  end

  // Read-word selection. The post-write word includes the other port's bytes
  // only when both ports hit the same address.
  always_comb begin
    old_a_s  = mem[bus.addr_a];
    old_b_s  = mem[bus.addr_b];
    post_a_s = byte_merge(old_a_s, bus.data_a, be_a_eff_s);
    post_a_s = byte_merge(post_a_s, bus.data_b, same_addr_s ? be_b_eff_s : BE_ZERO);
    post_b_s = byte_merge(old_b_s, bus.data_b, be_b_eff_s);
    post_b_s = byte_merge(post_b_s, bus.data_a, same_addr_s ? be_a_eff_s : BE_ZERO);
    rdat_a_s = (WRITE_FIRST && wr_a_s) ? post_a_s : old_a_s;
    rdat_b_s = (WRITE_FIRST && wr_b_s) ? post_b_s : old_b_s;
  end

  // Memory array: byte-granular writes. Lanes of A and B never overlap here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (be_a_eff_s[i]) begin
        mem[bus.addr_a][8*i +: 8] <= bus.data_a[8*i +: 8];
      end
      if (be_b_eff_s[i]) begin
        mem[bus.addr_b][8*i +: 8] <= bus.data_b[8*i +: 8];
      end
    end
  end

  // First read stage next state. Data holds unless a read completes.
  always_comb begin
    s1_va_d = rd_a_s;
    s1_vb_d = rd_b_s;
    s1_qa_d = rd_a_s ? rdat_a_s : s1_qa_q;
    s1_qb_d = rd_b_s ? rdat_b_s : s1_qb_q;
    coll_d  = wr_a_s & wr_b_s & same_addr_s & (|(bus.be_a & bus.be_b));
  end

  // First read stage and collision flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_qa_q <= DATA_ZERO;
      s1_qb_q <= DATA_ZERO;
      s1_va_q <= 1'b0;
      s1_vb_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      s1_qa_q <= s1_qa_d;
      s1_qb_q <= s1_qb_d;
      s1_va_q <= s1_va_d;
      s1_vb_q <= s1_vb_d;
      coll_q  <= coll_d;
    end
  end

  generate
    if (OUT_REG != 32'sd0) begin : g_out_reg
      logic [DATA_W-1:0] s2_qa_q, s2_qa_d, s2_qb_q, s2_qb_d;
      logic              s2_va_q, s2_va_d, s2_vb_q, s2_vb_d;

      // Output stage next state. Data moves only when a read is in flight.
      always_comb begin
        s2_va_d = s1_va_q;
        s2_vb_d = s1_vb_q;
        s2_qa_d = s1_va_q ? s1_qa_q : s2_qa_q;
        s2_qb_d = s1_vb_q ? s1_qb_q : s2_qb_q;
      end

      // Output stage registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_qa_q <= DATA_ZERO;
          s2_qb_q <= DATA_ZERO;
          s2_va_q <= 1'b0;
          s2_vb_q <= 1'b0;
        end else begin
          s2_qa_q <= s2_qa_d;
          s2_qb_q <= s2_qb_d;
          s2_va_q <= s2_va_d;
          s2_vb_q <= s2_vb_d;
        end
      end

      assign bus.qa       = s2_qa_q;
      assign bus.qb       = s2_qb_q;
      assign bus.qa_valid = s2_va_q;
      assign bus.qb_valid = s2_vb_q;
    end else begin : g_no_out_reg
      assign bus.qa       = s1_qa_q;
      assign bus.qb       = s1_qb_q;
      assign bus.qa_valid = s1_va_q;
      assign bus.qb_valid = s1_vb_q;
    end
  endgenerate

  assign bus.coll = coll_q;

endmodule
